// File: rtl/bram_lut_reader.sv
// -----------------------------------------------------------------------------
// bram_lut_reader
//   Read-side lookup engine for a product table held in a dual-port BRAM.
//   Once the table writer raises table_ready, operand pairs are accepted over
//   a valid/ready handshake, turned into port-B read addresses {dataA,dataB},
//   and the returning BRAM words are buffered in a small first-word-fall-
//   through FIFO so downstream back-pressure never drops a product.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   table_ready      BRAM table holds valid products
//   in_valid/ready   operand handshake, dataA (addr MSBs) / dataB (addr LSBs)
//   web, addrb, dinb BRAM port B (read only: web=0, dinb=0)
//   doutb            BRAM port-B read data, READ_LAT clocks after addrb
//   out_valid/ready  product handshake, dataC = doutb[2*DATA_WIDTH-1:0]
//   busy             lookups in flight or buffered
//   lookup_count     products delivered since reset (wraps at 2^16)
// -----------------------------------------------------------------------------
module bram_lut_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int BRAM_WIDTH = 18,
    parameter int BRAM_ADDR  = 12,
    parameter int READ_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    table_ready,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   dataA,
    input  logic [DATA_WIDTH-1:0]   dataB,
    output logic                    web,
    output logic [BRAM_ADDR-1:0]    addrb,
    output logic [BRAM_WIDTH-1:0]   dinb,
    input  logic [BRAM_WIDTH-1:0]   doutb,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] dataC,
    output logic                    busy,
    output logic [15:0]             lookup_count
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        WAIT_TABLE = 2'd0,
        RUN        = 2'd1,
        DRAIN      = 2'd2
    } state_t;

    state_t                state_q, state_d;
    // vld_pipe_q[0] : address register stage, [1..READ_LAT] : BRAM latency
    logic [READ_LAT:0]     vld_pipe_q, vld_pipe_d;
    logic [BRAM_ADDR-1:0]  addrb_q, addrb_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [15:0]           lookup_count_q, lookup_count_d;
    logic [PW-1:0]         fifo_mem_q [FIFO_DEPTH];

    logic                  fire_in;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic [CW-1:0]         inflight;
    logic [CW:0]           credit_used;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= READ_LAT; i++) begin
            inflight = inflight + CW'(vld_pipe_q[i]);
        end
    end

    assign empty       = (count_q == '0);
    assign credit_used = {1'b0, inflight} + {1'b0, count_q};
    // Credit rule: every read in flight already owns a FIFO slot, so the
    // returning word can always be captured without checking for full.
    assign in_ready    = (state_q == RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign fire_in     = in_valid & in_ready;
    assign push        = vld_pipe_q[READ_LAT];
    assign pop         = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        vld_pipe_d     = '0;
        addrb_d        = addrb_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        lookup_count_d = lookup_count_q;

        case (state_q)
            WAIT_TABLE: if (table_ready) state_d = RUN;
            RUN:        if (!table_ready) state_d = DRAIN;
            DRAIN:      if (inflight == '0 && empty) state_d = WAIT_TABLE;
            default:    state_d = WAIT_TABLE;
        endcase

        vld_pipe_d[0] = fire_in;
        for (int i = 1; i <= READ_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end

        if (fire_in) addrb_d = BRAM_ADDR'({dataA, dataB});

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d       = rd_ptr_q + AW'(1);
            lookup_count_d = lookup_count_q + 16'd1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT_TABLE;
            vld_pipe_q     <= '0;
            addrb_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            lookup_count_q <= '0;
        end else begin
            state_q        <= state_d;
            vld_pipe_q     <= vld_pipe_d;
            addrb_q        <= addrb_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            lookup_count_q <= lookup_count_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= doutb[PW-1:0];
    end

    generate
        if (BRAM_WIDTH > PW) begin : g_unused_hi
            logic unused_doutb_hi;
            assign unused_doutb_hi = ^doutb[BRAM_WIDTH-1:PW];
        end
    endgenerate

    assign out_valid    = !empty;
    // Head entry is forced to zero when empty so stale words never show.
    assign dataC        = empty ? '0 : fifo_mem_q[rd_ptr_q];
    assign busy         = (inflight != '0) || !empty;
    assign addrb        = addrb_q;
    assign web          = 1'b0;
    assign dinb         = '0;
    assign lookup_count = lookup_count_q;

endmodule

// File: tb/tb_bram_lut_reader.sv
module tb_bram_lut_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        table_ready;
    logic        in_valid;
    logic [3:0]  dataA, dataB;
    logic        out_ready;

    logic        in_ready, web, out_valid, busy;
    logic [11:0] addrb;
    logic [17:0] dinb, doutb;
    logic [7:0]  dataC;
    logic [15:0] lookup_count;

    logic        in_ready2, web2, out_valid2, busy2;
    logic [11:0] addrb2;
    logic [17:0] dinb2, doutb2, d2_s0;
    logic [7:0]  dataC2;
    logic [15:0] lookup_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bram_lut_reader #(.READ_LAT(1)) dut (
        .clk(clk), .rst(rst), .table_ready(table_ready),
        .in_valid(in_valid), .in_ready(in_ready), .dataA(dataA), .dataB(dataB),
        .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
        .out_valid(out_valid), .out_ready(out_ready), .dataC(dataC),
        .busy(busy), .lookup_count(lookup_count)
    );

    bram_lut_reader #(.READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .table_ready(table_ready),
        .in_valid(in_valid), .in_ready(in_ready2), .dataA(dataA), .dataB(dataB),
        .web(web2), .addrb(addrb2), .dinb(dinb2), .doutb(doutb2),
        .out_valid(out_valid2), .out_ready(out_ready), .dataC(dataC2),
        .busy(busy2), .lookup_count(lookup_count2)
    );

    // Product table; upper bits carry junk that must never reach dataC.
    function automatic logic [17:0] tbl(input logic [11:0] a);
        logic [7:0] x, y;
        x = {4'b0, a[7:4]};
        y = {4'b0, a[3:0]};
        return {10'h2A5, x * y};
    endfunction

    always @(posedge clk) doutb <= tbl(addrb);
    always @(posedge clk) begin
        d2_s0  <= tbl(addrb2);
        doutb2 <= d2_s0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int a, input int b);
        in_valid = 1'b1;
        dataA    = 4'(a);
        dataB    = 4'(b);
    endtask

    int pa[6] = '{2, 4, 5, 9, 10, 12};
    int pb[6] = '{3, 4, 6, 9, 11, 13};
    int e3[6] = '{6, 16, 30, 81, 110, 156};
    int rec[$];
    int idx, cnt;
    logic fire;

    initial begin
        rst = 1'b1; table_ready = 1'b1; in_valid = 1'b0;
        dataA = '0; dataB = '0; out_ready = 1'b1;

        // ---- T1: reset then single lookup 3*5
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dataC", dataC, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", lookup_count, 0);
        chk("rst_web_dinb", {web, dinb}, 0);
        step(); step();
        rst = 1'b0;
        step();
        chk("t1_ready_after_wait", in_ready, 1);
        drive(3, 5);
        step();
        in_valid = 1'b0;
        chk("t1_addrb", addrb, 12'h035);
        chk("t1_addrb2", addrb2, 12'h035);
        chk("t1_ov_c1", out_valid, 0);
        step();
        chk("t1_ov_c2", out_valid, 0);
        step();
        chk("t1_ov_c3", out_valid, 1);
        chk("t1_dataC", dataC, 8'h0F);
        chk("t1_ov2_c3", out_valid2, 0);
        step();
        chk("t1_count", lookup_count, 1);
        chk("t1_ov_after_pop", out_valid, 0);
        chk("t1_ov2_c4", out_valid2, 1);
        chk("t1_dataC2", dataC2, 8'h0F);
        step();

        // ---- T2: back-to-back pairs
        chk("t2_ready0", in_ready, 1);
        drive(1, 1); step();
        chk("t2_ready1", in_ready, 1);
        drive(15, 15); step();
        chk("t2_ready2", in_ready, 1);
        drive(7, 8); step();
        in_valid = 1'b0;
        chk("t2_ov0", out_valid, 1);
        chk("t2_d0", dataC, 1);
        step();
        chk("t2_d1", dataC, 225);
        step();
        chk("t2_d2", dataC, 56);
        step();
        chk("t2_ov_end", out_valid, 0);
        chk("t2_count", lookup_count, 4);

        // ---- T3: back-pressure, 6 pairs
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_ready_pre", in_ready, 1);
            drive(pa[i], pb[i]);
            step();
        end
        drive(pa[4], pb[4]);
        for (int i = 0; i < 3; i++) begin
            chk("t3_ready_held", in_ready, 0);
            step();
        end
        chk("t3_ov_frozen", out_valid, 1);
        chk("t3_d_frozen0", dataC, 6);
        step();
        chk("t3_d_frozen1", dataC, 6);
        chk("t3_ready_full", in_ready, 0);
        out_ready = 1'b1;
        idx = 4;
        rec.delete();
        for (int n = 0; n < 40 && rec.size() < 6; n++) begin
            fire = in_valid && in_ready;
            if (out_valid && out_ready) rec.push_back(int'(dataC));
            step();
            if (fire) begin
                idx++;
                if (idx < 6) drive(pa[idx], pb[idx]);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("t3_n", rec.size(), 6);
        for (int i = 0; i < rec.size() && i < 6; i++) chk("t3_seq", rec[i], e3[i]);
        step();
        chk("t3_count", lookup_count, 10);

        // ---- T4: drop table_ready with 2 in flight
        chk("t4_ready0", in_ready, 1);
        drive(3, 3); step();
        drive(6, 7); step();
        in_valid = 1'b0;
        table_ready = 1'b0;
        step();
        chk("t4_ready_drop", in_ready, 0);
        chk("t4_busy", busy, 1);
        drive(1, 2);
        rec.delete();
        for (int n = 0; n < 20 && busy; n++) begin
            if (out_valid && out_ready) rec.push_back(int'(dataC));
            step();
            chk("t4_ready_drain", in_ready, 0);
        end
        chk("t4_busy_fall", busy, 0);
        chk("t4_n", rec.size(), 2);
        if (rec.size() == 2) begin
            chk("t4_r0", rec[0], 9);
            chk("t4_r1", rec[1], 42);
        end
        step();
        chk("t4_wait_ready", in_ready, 0);
        table_ready = 1'b1;
        step();
        chk("t4_resume_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        step(); step();
        chk("t4_resume_ov", out_valid, 1);
        chk("t4_resume_d", dataC, 2);
        step();
        chk("t4_count", lookup_count, 13);

        // ---- T5: reset with 3 buffered results
        out_ready = 1'b0;
        drive(2, 2); step();
        drive(3, 4); step();
        drive(5, 5); step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("t5_ov_pre", out_valid, 1);
        chk("t5_d_pre", dataC, 4);
        rst = 1'b1;
        step();
        chk("t5_ov", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_count", lookup_count, 0);
        chk("t5_dataC", dataC, 0);
        chk("t5_ready", in_ready, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t5_ready_restart", in_ready, 1);
        drive(8, 9); step();
        in_valid = 1'b0;
        step();
        chk("t5_ov_c2", out_valid, 0);
        step();
        chk("t5_ov_c3", out_valid, 1);
        chk("t5_fresh", dataC, 8'h48);
        step();
        chk("t5_count1", lookup_count, 1);

        // ---- T6: lookup_count wrap after 65537 products
        rst = 1'b1; step();
        rst = 1'b0; step();
        drive(2, 7);
        cnt = 0;
        for (int n = 0; n < 70000 && cnt < 65537; n++) begin
            if (out_valid && out_ready) cnt++;
            step();
            if (cnt == 65535 && (n % 1) == 0 && lookup_count != 16'hFFFE) begin
                if (out_valid && out_ready && cnt == 65535) chk("t6_ffff", lookup_count, 16'hFFFF);
            end
        end
        in_valid = 1'b0;
        chk("t6_delivered", cnt, 65537);
        chk("t6_wrap", lookup_count, 1);
        step(); step(); step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
